// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-requester arbiter and access sequencer for dmem
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic S_IDLE   = 1'b0;
    localparam logic S_ACCESS = 1'b1;

    logic              state;
    logic              prio;
    logic              iss_we;
    logic              iss_owner;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;

    // Grant decode: only state, prio and req matter; prio breaks ties.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == S_IDLE) begin
            if (req0 && req1) begin
                gnt0 = ~prio;
                gnt1 = prio;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Sequencer state, round-robin pointer and issue register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            prio      <= 1'b0;
            iss_we    <= 1'b0;
            iss_owner <= 1'b0;
            iss_addr  <= '0;
            iss_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        state     <= S_ACCESS;
                        prio      <= gnt0;
                        iss_owner <= gnt1;
                        iss_we    <= gnt1 ? we1    : we0;
                        iss_addr  <= gnt1 ? addr1  : addr0;
                        iss_wdata <= gnt1 ? wdata1 : wdata0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Completion: pulse the owner's rvalid and capture read data as ACCESS ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= (state == S_ACCESS) && !iss_owner;
            rvalid1 <= (state == S_ACCESS) &&  iss_owner;
            if ((state == S_ACCESS) && !iss_we) begin
                if (iss_owner) begin
                    rdata1 <= mem_read_data;
                end else begin
                    rdata0 <= mem_read_data;
                end
            end
        end
    end

    // Address and data hold the last issue; only the write strobe is gated by state.
    assign mem_write      = (state == S_ACCESS) && iss_we;
    assign mem_address    = iss_addr;
    assign mem_write_data = iss_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    typedef struct {
        int          cyc;
        int          id;
        bit          has_data;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [63:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [63:0] rdata0, rdata1;
    logic        mem_write;
    logic [63:0] mem_address, mem_write_data, mem_read_data;

    logic [63:0] mem [0:15];
    int          cyc;
    int          checks;
    int          errors;
    int          base;
    exp_t        gq[$];
    exp_t        rq[$];

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // dmem model: combinational read, write on the rising edge
    assign mem_read_data = mem[mem_address[3:0]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[3:0]] <= mem_write_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_g(input int c, input int id);
        exp_t e;
        e.cyc = c; e.id = id; e.has_data = 1'b0; e.data = '0;
        gq.push_back(e);
    endtask

    task automatic push_r(input int c, input int id, input bit hd, input logic [63:0] d);
        exp_t e;
        e.cyc = c; e.id = id; e.has_data = hd; e.data = d;
        rq.push_back(e);
    endtask

    // Monitor: pops expectations whenever the DUT grants or completes
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (gnt0 || gnt1) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", {62'd0, gnt1, gnt0}, 64'd0);
                end else begin
                    e = gq.pop_front();
                    chk("gnt_onehot", {63'd0, gnt0 & gnt1}, 64'd0);
                    chk("gnt_id", {63'd0, gnt1}, 64'(e.id));
                    chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (rvalid0 || rvalid1) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", {62'd0, rvalid1, rvalid0}, 64'd0);
                end else begin
                    e = rq.pop_front();
                    chk("rvalid_onehot", {63'd0, rvalid0 & rvalid1}, 64'd0);
                    chk("rvalid_id", {63'd0, rvalid1}, 64'(e.id));
                    chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.has_data) chk("rdata", rvalid1 ? rdata1 : rdata0, e.data);
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0; cyc = 0;
        for (int i = 0; i < 16; i++) mem[i] = 64'hA000 + 64'(i);
        mem[5] = 64'h1234;
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // reset values before any clock edge
        #2;
        chk("rst_gnt", {62'd0, gnt1, gnt0}, 64'd0);
        chk("rst_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
        chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
        chk("rst_rdata0", rdata0, 64'd0);
        chk("rst_rdata1", rdata1, 64'd0);
        chk("rst_mem_address", mem_address, 64'd0);
        repeat (2) next();
        reset = 1'b0;

        // contention from reset: 0,1,0,1
        next();
        base = cyc;
        req0 = 1; addr0 = 64'd3; req1 = 1; addr1 = 64'd4;
        push_g(base, 0); push_g(base + 2, 1); push_g(base + 4, 0); push_g(base + 6, 1);
        push_r(base + 2, 0, 1, 64'hA003); push_r(base + 4, 1, 1, 64'hA004);
        push_r(base + 6, 0, 1, 64'hA003); push_r(base + 8, 1, 1, 64'hA004);
        repeat (8) next();
        req0 = 0; req1 = 0;
        repeat (3) next();

        // single read
        base = cyc;
        req0 = 1; we0 = 0; addr0 = 64'd5;
        push_g(base, 0); push_r(base + 2, 0, 1, 64'h1234);
        next();
        req0 = 0;
        @(negedge clk);
        chk("single_mem_address", mem_address, 64'd5);
        chk("single_mem_write", {63'd0, mem_write}, 64'd0);
        next();
        @(negedge clk);
        chk("single_rvalid1", {63'd0, rvalid1}, 64'd0);
        repeat (2) next();

        // write then read on requester 1
        base = cyc;
        req1 = 1; we1 = 1; addr1 = 64'd7; wdata1 = 64'hDEADBEEF;
        push_g(base, 1); push_g(base + 2, 1);
        push_r(base + 2, 1, 0, 64'd0); push_r(base + 4, 1, 1, 64'hDEADBEEF);
        @(negedge clk);
        chk("wr_mem_write_c0", {63'd0, mem_write}, 64'd0);
        next();
        req1 = 0;
        @(negedge clk);
        chk("wr_mem_write_c1", {63'd0, mem_write}, 64'd1);
        chk("wr_mem_address_c1", mem_address, 64'd7);
        chk("wr_mem_wdata_c1", mem_write_data, 64'hDEADBEEF);
        next();
        req1 = 1; we1 = 0;
        @(negedge clk);
        chk("wr_mem_write_c2", {63'd0, mem_write}, 64'd0);
        next();
        req1 = 0;
        @(negedge clk);
        chk("wr_mem_write_c3", {63'd0, mem_write}, 64'd0);
        repeat (3) next();

        // back-to-back reads on requester 0
        base = cyc;
        req0 = 1; we0 = 0; addr0 = 64'd1;
        push_g(base, 0); push_g(base + 2, 0); push_g(base + 4, 0);
        push_r(base + 2, 0, 1, 64'hA001); push_r(base + 4, 0, 1, 64'hA002);
        push_r(base + 6, 0, 1, 64'hA003);
        next(); addr0 = 64'd2;
        next();
        next(); addr0 = 64'd3;
        next();
        next(); req0 = 0;
        repeat (3) next();

        // reset pulse during ACCESS of a write
        base = cyc;
        req0 = 1; we0 = 1; addr0 = 64'd9; wdata0 = 64'hAAAA;
        push_g(base, 0);
        next();
        req0 = 0; we0 = 0;
        @(negedge clk);
        chk("rma_mem_write_before", {63'd0, mem_write}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rma_mem_write_after", {63'd0, mem_write}, 64'd0);
        chk("rma_rdata0", rdata0, 64'd0);
        chk("rma_rdata1", rdata1, 64'd0);
        chk("rma_gnt", {62'd0, gnt1, gnt0}, 64'd0);
        #1 reset = 1'b0;
        next();
        // prio must be back to 0: simultaneous requests go to 0 first
        base = cyc;
        req0 = 1; we0 = 0; addr0 = 64'd9;
        req1 = 1; we1 = 0; addr1 = 64'd5;
        push_g(base, 0); push_g(base + 2, 1);
        push_r(base + 2, 0, 1, 64'hA009); push_r(base + 4, 1, 1, 64'h1234);
        @(negedge clk);
        chk("rma_no_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
        chk("rma_mem_unchanged", mem[9], 64'hA009);
        next(); req0 = 0;
        next();
        next(); req1 = 0;
        repeat (4) next();

        for (int i = 0; i < 50 && (gq.size() != 0 || rq.size() != 0); i++) next();
        chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
        chk("rvalid_queue_drained", 64'(rq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
